// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter and busy scoreboard for the register file
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_addr,
  output logic [AW-1:0]     Aw,
  output logic [DW-1:0]     Dw,
  output logic              WrEn,
  output logic [31:0]       busy,
  output logic              conflict
);

  localparam int LW = $clog2(NREQ);

  logic [LW-1:0] last;
  logic [LW-1:0] idx;
  logic [LW-1:0] sel_idx;
  logic          sel_found;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [31:0]   busy_next;
  logic          rsv_hit;

  // Scan starts just past the last winner, so grant never depends on ready itself.
  always_comb begin
    req_ready = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last) + k) % NREQ);
      if (!sel_found && req_valid[idx]) begin
        sel_found      = 1'b1;
        sel_idx        = idx;
        req_ready[idx] = 1'b1;
      end
    end
  end

  assign sel_addr = req_addr[int'(sel_idx)*AW +: AW];
  assign sel_data = req_data[int'(sel_idx)*DW +: DW];
  assign rsv_hit  = rsv_valid && (rsv_addr != '0);

  // A reservation landing on the committing write's register belongs to a newer producer.
  always_comb begin
    busy_next = busy;
    if (WrEn)
      busy_next[Aw] = 1'b0;
    if (rsv_hit)
      busy_next[rsv_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= LW'(NREQ - 1);
      Aw       <= '0;
      Dw       <= '0;
      WrEn     <= 1'b0;
      busy     <= '0;
      conflict <= 1'b0;
    end else begin
      if (sel_found) begin
        last <= sel_idx;
        Aw   <= sel_addr;
        Dw   <= sel_data;
        WrEn <= (sel_addr != '0);
      end else begin
        WrEn <= 1'b0;
      end
      busy     <= busy_next;
      conflict <= rsv_hit && busy[rsv_addr] && !(WrEn && (Aw == rsv_addr));
    end
  end

endmodule
